// File: rtl/ofmap_collector_pkg.sv
// Shared configuration for the output-side collector: array geometry, row type and FSM encoding.
package ofmap_collector_pkg;

  localparam int sys_cols         = 4;
  localparam int P_BITWIDTH       = 16;
  localparam int OFMAP_FIFO_DEPTH = 4;

  typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] psum_row_t;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} collector_state_t;

endpackage

// File: rtl/ofmap_collector_col_fifo.sv
// Single-clock FIFO for one array column; a push into a full FIFO is accepted only when a pop frees a slot.
module col_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ofmap_collector.sv
// Re-aligns skewed per-column partial sums into full rows and streams one row per beat,
// counting rows against the tile size and pulsing tile_done after the last row is taken.
module ofmap_collector
  import ofmap_collector_pkg::*;
#(
  parameter int COLS  = sys_cols,
  parameter int PW    = P_BITWIDTH,
  parameter int DEPTH = OFMAP_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COLS-1:0]          read_out,
  input  logic [COLS-1:0][PW-1:0]  o_data,
  input  logic                     tile_start,
  input  logic [15:0]              num_rows,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [COLS-1:0][PW-1:0]  out_row,
  output logic                     out_last,
  output logic                     busy,
  output logic                     tile_done,
  output logic                     overflow
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_COLLECT = COLLECT;
  localparam logic [1:0] ST_DONE    = DONE;

  logic [1:0]               state;
  logic [15:0]              row_cnt;
  logic [15:0]              num_rows_q;
  logic [COLS-1:0]          fifo_full;
  logic [COLS-1:0]          fifo_empty;
  logic [COLS-1:0][PW-1:0]  fifo_dout;
  logic [COLS-1:0]          drop;
  logic                     row_avail;
  logic                     load;
  logic                     hs;

  assign row_avail = ~|fifo_empty;
  assign hs        = out_valid & out_ready;
  // Rows past the tile size stay queued for the next tile.
  assign load      = (state == ST_COLLECT) && row_avail && (row_cnt != num_rows_q)
                     && (!out_valid || out_ready);
  assign drop      = read_out & fifo_full & {COLS{~load}};
  assign busy      = (state == ST_COLLECT);
  assign tile_done = (state == ST_DONE);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    col_fifo #(
      .W     (PW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (read_out[c]),
      .din   (o_data[c]),
      .pop   (load),
      .dout  (fifo_dout[c]),
      .full  (fifo_full[c]),
      .empty (fifo_empty[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row_cnt    <= '0;
      num_rows_q <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_row    <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tile_start) begin
            num_rows_q <= num_rows;
            row_cnt    <= '0;
            state      <= (num_rows != 16'd0) ? ST_COLLECT : ST_DONE;
          end
        end
        ST_COLLECT: begin
          if (hs && out_last) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase

      if (load) begin
        out_row   <= fifo_dout;
        out_valid <= 1'b1;
        out_last  <= (row_cnt == num_rows_q - 16'd1);
        row_cnt   <= row_cnt + 16'd1;
      end else if (hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      // A drop in the tile_start cycle still marks the new tile as overflowed.
      if (state == ST_IDLE && tile_start) overflow <= 1'b0;
      if (|drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ofmap_collector.sv
// Scoreboarded bench: stimulus queues expected rows, a negedge monitor checks every accepted row and tile status.
module tb_ofmap_collector;

  localparam int COLS  = 4;
  localparam int PW    = 16;
  localparam int DEPTH = 4;

  typedef logic [COLS-1:0][PW-1:0] row_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [COLS-1:0] read_out = '0;
  row_t            o_data = '0;
  logic            tile_start = 1'b0;
  logic [15:0]     num_rows = '0;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic            out_last;
  logic            busy;
  logic            tile_done;
  logic            overflow;
  row_t            out_row;

  int   n_tests = 0;
  int   n_fail = 0;
  row_t exp_rows[$];
  int   tile_n = 0;
  int   tile_idx = 0;
  int   tiles_done = 0;
  bit   active = 1'b0;
  bit   done_exp = 1'b0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  ofmap_collector #(
    .COLS  (COLS),
    .PW    (PW),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .read_out   (read_out),
    .o_data     (o_data),
    .tile_start (tile_start),
    .num_rows   (num_rows),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_last   (out_last),
    .busy       (busy),
    .tile_done  (tile_done),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: rows leave in feed order; tile membership decides out_last and tile_done.
  always @(negedge clk) begin
    bit   next_done;
    bit   exp_last;
    row_t er;
    if (rst) begin
      exp_rows.delete();
      active   = 1'b0;
      done_exp = 1'b0;
    end else begin
      next_done = 1'b0;
      check("tile_done", 64'(tile_done), 64'(done_exp));
      if (done_exp) tiles_done++;
      check("busy", 64'(busy), 64'(active));
      if (out_valid && out_ready) begin
        if (exp_rows.size() == 0) begin
          check("row_with_empty_scoreboard", 64'(out_valid), 64'(0));
        end else begin
          er       = exp_rows.pop_front();
          exp_last = (tile_idx == tile_n - 1);
          check("row_data", out_row, er);
          check("row_last", 64'(out_last), 64'(exp_last));
          tile_idx++;
          if (exp_last) begin
            active    = 1'b0;
            next_done = 1'b1;
          end
        end
      end
      if (tile_start && !active && !done_exp) begin
        tile_n   = int'(num_rows);
        tile_idx = 0;
        if (num_rows == 16'd0) next_done = 1'b1;
        else active = 1'b1;
      end
      done_exp = next_done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_tile(input int n);
    tile_start = 1'b1;
    num_rows   = 16'(n);
    tick();
    tile_start = 1'b0;
  endtask

  task automatic feed_row(input row_t r);
    read_out = '1;
    o_data   = r;
    exp_rows.push_back(r);
    tick();
    read_out = '0;
  endtask

  task automatic wait_tiles(input int target);
    int cyc = 0;
    while (tiles_done < target && cyc < 500) begin
      tick();
      cyc++;
    end
    check("tile_completion", 64'(tiles_done), 64'(target));
    tick();
  endtask

  task automatic pace();
    int cyc = 0;
    while (exp_rows.size() >= DEPTH && cyc < 500) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t        r;
    row_t        r0;
    logic [PW-1:0] c0 [5];
    int          carry;
    int          n;
    int          need;
    int          extra;
    int          target;
    int          cyc;

    repeat (3) tick();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last",  64'(out_last),  64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_tile_done", 64'(tile_done), 64'(0));
    check("rst_overflow",  64'(overflow),  64'(0));
    check("rst_out_row",   out_row,        64'(0));

    // Aligned rows: column c of row r carries 10*r+c.
    out_ready = 1'b1;
    target = tiles_done + 1;
    start_tile(3);
    for (int ri = 0; ri < 3; ri++) begin
      for (int c = 0; c < COLS; c++) r[c] = PW'(10 * ri + c);
      feed_row(r);
    end
    wait_tiles(target);

    // Column skew: column c strobed c cycles late.
    target = tiles_done + 1;
    start_tile(1);
    r = {$urandom, $urandom};
    exp_rows.push_back(r);
    for (int c = 0; c < COLS; c++) begin
      read_out    = '0;
      read_out[c] = 1'b1;
      o_data      = r;
      tick();
    end
    read_out = '0;
    check("skew_not_early", 64'(out_valid), 64'(0));
    tick();
    check("skew_latency", 64'(out_valid), 64'(1));
    wait_tiles(target);

    // Backpressure: first row must sit still while the second waits in the FIFOs.
    out_ready = 1'b0;
    target = tiles_done + 1;
    start_tile(2);
    r0 = {$urandom, $urandom};
    feed_row(r0);
    feed_row({$urandom, $urandom});
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bp_valid_seen", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", 64'(out_valid), 64'(1));
      check("bp_row_hold", out_row, r0);
    end
    out_ready = 1'b1;
    wait_tiles(target);

    // Overflow: five pushes into column 0 while idle; the fifth is lost.
    for (int i = 0; i < 5; i++) begin
      c0[i]     = PW'($urandom);
      read_out  = 4'b0001;
      o_data    = '0;
      o_data[0] = c0[i];
      tick();
      read_out = '0;
      if (i == 3) check("overflow_at_full", 64'(overflow), 64'(0));
    end
    check("overflow_set", 64'(overflow), 64'(1));
    target = tiles_done + 1;
    start_tile(4);
    check("overflow_cleared", 64'(overflow), 64'(0));
    for (int ri = 0; ri < 4; ri++) begin
      r        = {$urandom, $urandom};
      r[0]     = c0[ri];
      read_out = 4'b1110;
      o_data   = r;
      exp_rows.push_back(r);
      tick();
      read_out = '0;
    end
    wait_tiles(target);

    // Zero-row tile.
    target = tiles_done + 1;
    start_tile(0);
    check("zero_tile_done", 64'(tile_done), 64'(1));
    check("zero_busy",      64'(busy),      64'(0));
    check("zero_out_valid", 64'(out_valid), 64'(0));
    wait_tiles(target);

    // Reset in the middle of a 4-row tile.
    start_tile(4);
    feed_row({$urandom, $urandom});
    feed_row({$urandom, $urandom});
    cyc = 0;
    while (exp_rows.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    feed_row({$urandom, $urandom});
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_out_last",  64'(out_last),  64'(0));
    check("midrst_busy",      64'(busy),      64'(0));
    check("midrst_tile_done", 64'(tile_done), 64'(0));
    check("midrst_overflow",  64'(overflow),  64'(0));
    check("midrst_out_row",   out_row,        64'(0));
    out_ready = 1'b1;
    target = tiles_done + 1;
    start_tile(1);
    feed_row({$urandom, $urandom});
    wait_tiles(target);

    // Random tiles with random backpressure; sometimes a spare row carries into the next tile.
    rand_ready = 1'b1;
    carry = 0;
    for (int t = 0; t < 12; t++) begin
      n      = $urandom_range(1, 6);
      need   = n - carry;
      extra  = (t < 11) ? $urandom_range(0, 1) : 0;
      target = tiles_done + 1;
      start_tile(n);
      for (int i = 0; i < need + extra; i++) begin
        pace();
        repeat ($urandom_range(0, 2)) tick();
        feed_row({$urandom, $urandom});
      end
      wait_tiles(target);
      carry = extra;
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    check("random_no_overflow", 64'(overflow), 64'(0));
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ofmap_collector.md
# ofmap_collector

Output-side stage that sits directly downstream of the matmul accelerator top level. It consumes the skewed per-column partial-sum stream (`read_out` strobes plus `o_data`) and buffers each column independently. It re-aligns the columns into complete output rows and hands one row per beat to the writeback path over a valid/ready handshake, counting rows against a per-tile row count and flagging tile completion.

## Interface
Parameters:
- `COLS`, default `sys_cols`: number of array columns.
- `PW`, default `P_BITWIDTH`: partial-sum width.
- `DEPTH`, default 4: per-column FIFO depth; power of two, ≥ 2.

Ports:
- `clk`, in, 1: single clock; all state changes on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `read_out`, in, COLS: per-column write strobe from the array.
- `o_data`, in, COLS×PW: per-column partial sums, qualified by `read_out[c]`.
- `tile_start`, in, 1: begin a tile; samples `num_rows`.
- `num_rows`, in, 16: number of rows in the tile.
- `out_valid`, out, 1: `out_row` holds a complete row.
- `out_ready`, in, 1: downstream accepts the row.
- `out_row`, out, COLS×PW: aligned output row.
- `out_last`, out, 1: qualifies the final row of the tile.
- `busy`, out, 1: high in COLLECT.
- `tile_done`, out, 1: one-cycle pulse after the last row is accepted.
- `overflow`, out, 1: sticky; a column write was dropped.

## Operation
- Per-column FIFO `c`:
  - Pushes `o_data[c]` when `read_out[c]=1`, in any FSM state.
  - If the FIFO is full with no pop in the same cycle, the push is dropped and `overflow` is set.
  - Full with a simultaneous pop: the push is accepted.
- Row available: all COLS FIFOs non-empty.
- Output register load condition: state COLLECT, row available, and (`!out_valid` or `out_ready`).
  - Pops every FIFO in the same cycle.
  - Loads `out_row`, sets `out_valid=1`.
  - Sets `out_last=1` iff the row index equals `num_rows_q-1`.
  - Increments the row counter.
- If `out_valid && out_ready` and no load occurs, `out_valid` clears.
- FSM:
  - IDLE:
    - On `tile_start`: latch `num_rows` into `num_rows_q`, clear the row counter, clear `overflow`.
    - Next state is COLLECT if `num_rows≠0`, else DONE.
  - COLLECT:
    - Loads rows as above.
    - On `out_valid && out_ready && out_last`, go to DONE.
    - `tile_start` is ignored.
    - Rows beyond `num_rows_q` are not loaded; they stay in the FIFOs for the next tile.
  - DONE: `tile_done=1` for exactly one cycle, then IDLE.
- `out_row` is held stable while `out_valid && !out_ready`. AXI-style rule: `out_valid` never depends combinationally on `out_ready`.
- Data width: pass-through, no arithmetic on `o_data`. The row counter is 16 bits and cannot wrap, since it stops at `num_rows_q`.

## Timing
- Reset values:
  - `out_valid`, `out_last`, `busy`, `tile_done`, `overflow`: 0.
  - `out_row`: 0.
  - FIFOs empty, row counter 0, state IDLE.
- Latency: with the last missing column strobed in cycle n and the output register free, `out_valid` is high in cycle n+2.
- Throughput: one row per cycle when `out_ready` is held high and the FIFOs are fed.
- Column skew: tolerated up to DEPTH-1 entries per column before overflow.
- `tile_done` is high in the cycle after the final handshake.
- Reset mid-tile: all FIFO contents and the in-flight row are discarded; no `tile_done` is produced.
- `tile_start` in the same cycle as `rst`: `rst` wins.

## Structure
- Config package additions:
  - `typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] psum_row_t`.
  - `typedef enum {IDLE, COLLECT, DONE} collector_state_t`.
  - `localparam OFMAP_FIFO_DEPTH = 4`.
- Sub-module `col_fifo`: synchronous single-clock FIFO of width PW and depth DEPTH, with push, pop, full, empty and simultaneous push/pop support. Instantiated COLS times in a generate loop.
- The FSM, row counter and output register live in `ofmap_collector`.

## Test plan
- Aligned rows: `num_rows=3`, `tile_start`; all columns strobed together, column c = 10·r+c, with `out_ready=1`. Expect three consecutive rows, `out_last` on row 2, and `tile_done` pulsed one cycle after it.
- Skew: COLS=4, column c strobed c cycles late, one row. Expect `out_valid` 2 cycles after column 3's strobe and the row values aligned.
- Backpressure: `out_ready=0` for 5 cycles with a row pending. Expect `out_row` and `out_valid` stable; no further FIFO pops; the row is released on the `out_ready` cycle.
- Overflow: strobe column 0 five times with DEPTH=4, other columns idle. Expect `overflow=1` and the fifth value lost. A subsequent `tile_start` clears `overflow`.
- Zero rows: `tile_start` with `num_rows=0`. Expect `tile_done` 1 cycle later, no `out_valid`, `busy` stays 0.
- Reset mid-tile: assert `rst` after row 1 of 4. Expect all outputs 0 the next cycle and FIFOs empty; a new 1-row tile then completes normally.
